fpcvt_arbiter: RTL and testbench
================================

# fpcvt_arbiter

Shares one combinational FPCVT converter (13-bit two's-complement linear to 9-bit sign/3-bit exponent/5-bit significand float) among N_REQ requesters. The block runs round-robin arbitration, captures the winning operand, registers the converted result, and holds it on a valid/ready output port tagged with the requester index. It sits between the sample-producing front ends and the display/encode stage.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- IDW, default 2: requester index width, must equal ceil(log2(N_REQ)).
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester operand valid.
- req_data  in  13*N_REQ  per-requester operand; requester i uses bits [13*i+12:13*i].
- req_ready  out  N_REQ  one-hot accept; at most one bit high per cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_s  out  1  sign.
- out_e  out  3  exponent.
- out_f  out  5  significand.
- out_id  out  IDW  index of the requester that supplied the operand.
- busy  out  1  high whenever state is not IDLE.
- out_sat  out  1  saturation flag; exists only with FPCVT_ARB_SAT_FLAG_EN.

## Operation
- FSM states: IDLE, CONV, OUT. Reset state is IDLE.
- IDLE:
  - If any req_valid bit is set, the grant is the first set bit searching upward from ptr+1, mod N_REQ.
  - req_ready[grant] is driven high combinationally in the same cycle.
  - Transfer happens on req_valid[g] & req_ready[g]. On transfer: op_reg <= req_data[g], id_reg <= g, ptr <= g, next state CONV.
  - If no req_valid bit is set, the FSM stays in IDLE and all req_ready bits are 0.
- CONV:
  - FPCVT instance is fed from op_reg.
  - Its S/E/F outputs and id_reg are registered into out_s/out_e/out_f/out_id. out_valid <= 1, next state OUT.
  - req_ready is all 0.
- OUT:
  - Outputs hold stable while out_valid & !out_ready.
  - On out_valid & out_ready: out_valid <= 0, next state IDLE. Data outputs keep their last value.
  - req_ready is all 0.
- Conversion arithmetic is exactly that of the FPCVT instance:
  - Magnitude, then leading-one exponent 0..7, then 5-bit significand, then round on the first dropped bit.
  - A significand overflow increments E and sets F=10000.
  - An exponent overflow clamps to E=7, F=31.
- Fairness: any requester holding req_valid is granted within N_REQ accepted transfers.
- Reset (rst_n low at a rising edge), including mid-transaction:
  - state=IDLE, ptr=N_REQ-1 so requester 0 wins first.
  - out_valid=0, out_s=0, out_e=0, out_f=0, out_id=0, out_sat=0, op_reg=0, id_reg=0.
  - While rst_n is low, req_ready is forced to 0 and busy reads 0.
  - A result held in OUT is discarded without handshake.

## Timing
- Latency from request to output:
  - Operand accepted at edge k.
  - Result registered at edge k+1; out_valid is high in the cycle after edge k+1.
- Throughput: one conversion per 3 cycles with out_ready held high.
- Output back-pressure stalls the FSM in OUT indefinitely. No operand is accepted during the stall.
- Requesters must hold req_valid and req_data until they see their ready. Dropping valid before accept is legal: the grant re-evaluates every IDLE cycle.
- With simultaneous requests, only the granted requester transfers. The others wait with ready=0.
- Out_valid and data are register outputs. Req_ready is combinational from req_valid, ptr and state only; it has no path from out_ready.

## Configuration
- FPCVT_ARB_SAT_FLAG_EN defined:
  - Port out_sat is present, registered in CONV alongside the result and held in OUT.
  - out_sat = 1 iff the operand magnitude is ≥ 4032, i.e. the rounder clamped to E=7, F=31. This covers D in 4032..4095 and −4096..−4032.
- Not defined: no out_sat port and no related logic. All other behaviour is identical.

## Test plan
- Reset then single request: req_valid=0001, D=422.
  - Expect req_ready=0001 in the same cycle, then out_valid two edges later.
  - Expect S=0, E=4, F=26, id=0, busy high until the output handshake.
- Rounding cases through requester 2:
  - D=125 → E=2, F=31.
  - D=126 → E=3, F=16.
  - D=−1 → S=1, E=0, F=1.
  - D=0 → S=0, E=0, F=0.
- All four requesters are held valid after reset.
  - Grant order is 0,1,2,3,0 with out_id matching each time.
  - Exactly one req_ready bit per accept, and exactly 3 cycles between accepts.
- out_ready is held low for 10 cycles in OUT.
  - Outputs stay stable, req_ready stays 0, and no new operand is accepted.
  - Releasing out_ready completes the handshake, and the next accept follows one cycle later.
- rst_n is asserted low in CONV and again in OUT.
  - On the next edge: out_valid=0, outputs 0, state IDLE.
  - After release, requester 0 has priority.
- With FPCVT_ARB_SAT_FLAG_EN:
  - D=4031 → E=7, F=31, sat=0.
  - D=4032 → E=7, F=31, sat=1.
  - D=−4096 → S=1, E=7, F=31, sat=1.
  - Also build without the macro to confirm there is no out_sat port.

Source files
------------

// File: rtl/fpcvt_arbiter_if.sv
// Requester / result bus for fpcvt_arbiter.
// out_sat exists only when FPCVT_ARB_SAT_FLAG_EN is defined.
interface fpcvt_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [13*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                out_valid;
  logic                out_ready;
  logic                out_s;
  logic [2:0]          out_e;
  logic [4:0]          out_f;
  logic [IDW-1:0]      out_id;
  logic                busy;
`ifdef FPCVT_ARB_SAT_FLAG_EN
  logic                out_sat;
`endif

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_s, out_e, out_f, out_id, busy
`ifdef FPCVT_ARB_SAT_FLAG_EN
    , input out_sat
`endif
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_s, out_e, out_f, out_id, busy
`ifdef FPCVT_ARB_SAT_FLAG_EN
    , output out_sat
`endif
  );
endinterface

// File: rtl/fpcvt_arbiter.sv
// Round-robin shared 13-bit linear -> S/E3/F5 float converter with registered, tagged result.
// Define FPCVT_ARB_SAT_FLAG_EN to add the out_sat clamp flag.
module fpcvt (
  input  logic [12:0] i_d,
  output logic        o_s,
  output logic [2:0]  o_e,
  output logic [4:0]  o_f
`ifdef FPCVT_ARB_SAT_FLAG_EN
  , output logic      o_sat
`endif
);
  logic [12:0] w_mag;
  logic [3:0]  w_msb;
  logic [3:0]  w_eraw;
  logic [3:0]  w_efin;
  logic [4:0]  w_sh;
  logic        w_rbit;
  logic [5:0]  w_sum;
  logic        w_ovf;

  always_comb begin
    w_mag = i_d[12] ? (~i_d + 13'd1) : i_d;
    w_msb = '0;
    for (int unsigned b = 0; b < 13; b++) begin
      if (w_mag[b]) w_msb = 4'(b);
    end
    w_eraw = (w_msb > 4'd4) ? (w_msb - 4'd4) : '0;
    w_sh   = 5'(w_mag >> w_eraw);
    w_rbit = (w_eraw != '0) ? w_mag[w_eraw - 4'd1] : 1'b0;
    // rounding carry out of the significand bumps the exponent
    w_sum  = {1'b0, w_sh} + {5'b0, w_rbit};
    w_efin = w_sum[5] ? (w_eraw + 4'd1) : w_eraw;
    w_ovf  = w_efin[3];
    o_s    = i_d[12];
    if (w_ovf) begin
      o_e = 3'd7;
      o_f = 5'd31;
    end else begin
      o_e = w_efin[2:0];
      o_f = w_sum[5] ? 5'b10000 : w_sum[4:0];
    end
  end

`ifdef FPCVT_ARB_SAT_FLAG_EN
  assign o_sat = w_ovf;
`endif
endmodule

module fpcvt_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
) (
  input logic             clk,
  input logic             rst_n,
  fpcvt_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [12:0]       r_op;
  logic              r_out_valid;
  logic              r_out_s;
  logic [2:0]        r_out_e;
  logic [4:0]        r_out_f;
  logic [IDW-1:0]    r_out_id;

  logic              w_found;
  logic [IDW-1:0]    w_grant;
  logic [IDW-1:0]    w_idx;
  logic [12:0]       w_op_sel;
  logic [N_REQ-1:0]  w_req_ready;
  logic              w_accept;
  logic              w_load;
  logic              w_release;
  logic              w_cvt_s;
  logic [2:0]        w_cvt_e;
  logic [4:0]        w_cvt_f;

`ifdef FPCVT_ARB_SAT_FLAG_EN
  logic              r_out_sat;
  logic              w_cvt_sat;
`endif

  fpcvt u_cvt (
    .i_d   (r_op),
    .o_s   (w_cvt_s),
    .o_e   (w_cvt_e),
    .o_f   (w_cvt_f)
`ifdef FPCVT_ARB_SAT_FLAG_EN
    , .o_sat (w_cvt_sat)
`endif
  );

  // First valid requester searching upward from ptr+1, wrapping at N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_idx = IDW'((32'(r_ptr) + i) % N_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_op_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant == IDW'(i)) w_op_sel = bus.req_data[13*i +: 13];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_req_ready[w_grant] = 1'b1;
          w_accept             = 1'b1;
          w_state_nxt          = CONV;
        end
      end
      CONV: begin
        w_load      = 1'b1;
        w_state_nxt = OUT;
      end
      OUT: begin
        if (r_out_valid && bus.out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!rst_n) w_req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= IDW'(N_REQ - 1);
      r_id        <= '0;
      r_op        <= '0;
      r_out_valid <= 1'b0;
      r_out_s     <= 1'b0;
      r_out_e     <= '0;
      r_out_f     <= '0;
      r_out_id    <= '0;
`ifdef FPCVT_ARB_SAT_FLAG_EN
      r_out_sat   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_op  <= w_op_sel;
        r_id  <= w_grant;
        r_ptr <= w_grant;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_s     <= w_cvt_s;
        r_out_e     <= w_cvt_e;
        r_out_f     <= w_cvt_f;
        r_out_id    <= r_id;
`ifdef FPCVT_ARB_SAT_FLAG_EN
        r_out_sat   <= w_cvt_sat;
`endif
      end
      if (w_release) r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_s     = r_out_s;
  assign bus.out_e     = r_out_e;
  assign bus.out_f     = r_out_f;
  assign bus.out_id    = r_out_id;
  assign bus.busy      = rst_n && (r_state != IDLE);
`ifdef FPCVT_ARB_SAT_FLAG_EN
  assign bus.out_sat   = r_out_sat;
`endif
endmodule

// File: tb/tb_fpcvt_arbiter.sv
// Bench for fpcvt_arbiter: transaction-level model checked every cycle, plus directed cases.
module tb_fpcvt_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fpcvt_arbiter_if #(.N_REQ(NR), .IDW(IW)) bus ();
  fpcvt_arbiter #(.N_REQ(NR), .IDW(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result packed as {sat, s, e[2:0], f[4:0]}; value ~ f * 2^e, round half up on first dropped bit.
  function automatic logic [9:0] m_cvt(input logic [12:0] d);
    int  m, e, f;
    logic s, sat;
    m = int'($signed(d));
    s = (m < 0);
    if (s) m = -m;
    e = 0;
    while (m >= (32 << e)) e++;
    f = (e == 0) ? m : ((m + (1 << (e - 1))) >> e);
    if (f == 32) begin
      e++;
      f = 16;
    end
    sat = (e > 7);
    if (sat) begin
      e = 7;
      f = 31;
    end
    return {sat, s, 3'(e), 5'(f)};
  endfunction

  function automatic int grant_of(input logic [NR-1:0] v, input int p);
    for (int j = 1; j <= int'(NR); j++) begin
      if (v[(p + j) % NR]) return (p + j) % NR;
    end
    return -1;
  endfunction

  typedef struct {
    logic [12:0] d;
    int          id;
    int          k;
  } txn_t;

  txn_t        q[$];
  int          m_ptr = NR - 1;
  logic [9:0]  m_last_res = '0;
  int          m_last_id = 0;
  int          edges = 0;
  bit          m_started = 1'b0;

  logic [NR-1:0] cm_rdy;
  int            cm_g;
  bit            cm_vld;
  logic [9:0]    cm_res;
  int            cm_id;

  // Compare process: one check pass per cycle, then advance the model across the coming edge.
  initial forever begin
    @(negedge clk);
    cm_g   = grant_of(bus.req_valid, m_ptr);
    cm_vld = 1'b0;
    if (m_started) begin
      cm_rdy = '0;
      if (rst_n && q.size() == 0 && cm_g >= 0) cm_rdy[cm_g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(cm_rdy));
      chk("busy", 32'(bus.busy), 32'(rst_n && q.size() != 0));
      cm_vld = (q.size() != 0) && (edges - q[0].k >= 1);
      chk("out_valid", 32'(bus.out_valid), 32'(cm_vld));
      if (cm_vld) begin
        cm_res = m_cvt(q[0].d);
        cm_id  = q[0].id;
      end else begin
        cm_res = m_last_res;
        cm_id  = m_last_id;
      end
      chk("out_s", 32'(bus.out_s), 32'(cm_res[8]));
      chk("out_e", 32'(bus.out_e), 32'(cm_res[7:5]));
      chk("out_f", 32'(bus.out_f), 32'(cm_res[4:0]));
      chk("out_id", 32'(bus.out_id), 32'(cm_id));
`ifdef FPCVT_ARB_SAT_FLAG_EN
      chk("out_sat", 32'(bus.out_sat), 32'(cm_res[9]));
`endif
    end
    if (!rst_n) begin
      q.delete();
      m_ptr      = NR - 1;
      m_last_res = '0;
      m_last_id  = 0;
      m_started  = 1'b1;
    end else if (m_started) begin
      if (q.size() == 0) begin
        if (cm_g >= 0) begin
          q.push_back('{d: bus.req_data[13*cm_g +: 13], id: cm_g, k: edges + 1});
          m_ptr = cm_g;
        end
      end else if (cm_vld && bus.out_ready) begin
        m_last_res = m_cvt(q[0].d);
        m_last_id  = q[0].id;
        void'(q.pop_front());
      end
    end
    edges++;
  end

  logic [12:0] corner [8] = '{13'd422, 13'd125, 13'd126, 13'h1FFF, 13'd0, 13'd4031, 13'd4032, 13'h1000};

  function automatic logic [12:0] rnd_d();
    if ($urandom % 3 == 0) return corner[$urandom % 8];
    return 13'($urandom);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string name, input logic [NR-1:0] mask);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.req_ready & mask) == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'd0);
  endtask

  // Lone request on an idle block: ready at once, result two edges after the accept.
  task automatic do_one(input int r, input logic [12:0] d, input logic es,
                        input logic [2:0] ee, input logic [4:0] ef, input logic esat);
    bus.out_ready = 1'b1;
    bus.req_data[13*r +: 13] = d;
    bus.req_valid[r] = 1'b1;
    wait_ready("accept_wait", NR'(1) << r);
    chk("ready_onehot", 32'(bus.req_ready), 32'(1) << r);
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b0;
    chk("conv_no_valid", 32'(bus.out_valid), 32'd0);
    chk("busy_conv", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("res_valid", 32'(bus.out_valid), 32'd1);
    chk("res_s", 32'(bus.out_s), 32'(es));
    chk("res_e", 32'(bus.out_e), 32'(ee));
    chk("res_f", 32'(bus.out_f), 32'(ef));
    chk("res_id", 32'(bus.out_id), 32'(r));
    chk("busy_out", 32'(bus.busy), 32'd1);
`ifdef FPCVT_ARB_SAT_FLAG_EN
    chk("res_sat", 32'(bus.out_sat), 32'(esat));
`else
    if (esat === 1'bx) $display("note: unexpected X flag");
`endif
    @(posedge clk); #1;
    chk("hs_done", 32'(bus.out_valid), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_zeroed(input string name);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({name, "_s"}, 32'(bus.out_s), 32'd0);
    chk({name, "_e"}, 32'(bus.out_e), 32'd0);
    chk({name, "_f"}, 32'(bus.out_f), 32'd0);
    chk({name, "_id"}, 32'(bus.out_id), 32'd0);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_ready"}, 32'(bus.req_ready), 32'd0);
`ifdef FPCVT_ARB_SAT_FLAG_EN
    chk({name, "_sat"}, 32'(bus.out_sat), 32'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  logic [NR-1:0] seen;
  logic          snap_s;
  logic [2:0]    snap_e;
  logic [4:0]    snap_f;
  logic [IW-1:0] snap_id;
  int            last_acc;
  int            n;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    chk("model_422", 32'(m_cvt(13'd422)), 32'({1'b0, 1'b0, 3'd4, 5'd26}));
    chk("model_126", 32'(m_cvt(13'd126)), 32'({1'b0, 1'b0, 3'd3, 5'd16}));
    chk("model_4032", 32'(m_cvt(13'd4032)), 32'({1'b1, 1'b0, 3'd7, 5'd31}));
    chk("model_m4096", 32'(m_cvt(13'h1000)), 32'({1'b1, 1'b1, 3'd7, 5'd31}));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_one(0, 13'd422, 1'b0, 3'd4, 5'd26, 1'b0);
    do_one(2, 13'd125, 1'b0, 3'd2, 5'd31, 1'b0);
    do_one(2, 13'd126, 1'b0, 3'd3, 5'd16, 1'b0);
    do_one(2, 13'h1FFF, 1'b1, 3'd0, 5'd1, 1'b0);
    do_one(2, 13'd0, 1'b0, 3'd0, 5'd0, 1'b0);
    do_one(1, 13'd4031, 1'b0, 3'd7, 5'd31, 1'b0);
    do_one(1, 13'd4032, 1'b0, 3'd7, 5'd31, 1'b1);
    do_one(3, 13'h1000, 1'b1, 3'd7, 5'd31, 1'b1);

    // All requesters held valid: 0,1,2,3,0 with 3 cycles between accepts
    do_reset();
    for (int i = 0; i < int'(NR); i++) bus.req_data[13*i +: 13] = rnd_d();
    bus.req_valid = '1;
    last_acc = 0;
    for (int a = 0; a < 5; a++) begin
      n = 0;
      @(negedge clk);
      while (bus.req_ready == '0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("rr_grant", 32'(bus.req_ready), 32'(1) << (a % NR));
      if (a > 0) chk("rr_spacing", 32'(cyc - last_acc), 32'd3);
      last_acc = cyc;
      @(posedge clk); #1;
      bus.req_data[13*(a % NR) +: 13] = rnd_d();
    end
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: 10 stalled cycles in OUT
    do_reset();
    bus.out_ready = 1'b0;
    bus.req_data[0 +: 13] = 13'd700;
    bus.req_valid = 4'b0111;
    wait_ready("bp_accept", '1);
    chk("bp_first", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    snap_s = bus.out_s; snap_e = bus.out_e; snap_f = bus.out_f; snap_id = bus.out_id;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_data", 32'({bus.out_s, bus.out_e, bus.out_f, bus.out_id}),
          32'({snap_s, snap_e, snap_f, snap_id}));
      chk("bp_no_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("bp_next_accept", 32'(bus.req_ready), 32'd2);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while converting
    do_reset();
    do_one(1, 13'h1ED4, 1'b1, 3'd4, 5'd19, 1'b0);
    bus.req_data[13*2 +: 13] = 13'd422;
    bus.req_valid[2] = 1'b1;
    wait_ready("rc_accept", '1);
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zeroed("rst_conv");
    rst_n = 1'b1;
    bus.req_valid = '1;
    @(negedge clk);
    chk("rst_conv_prio", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while holding a result
    bus.out_ready = 1'b0;
    bus.req_data[13*3 +: 13] = 13'h1ED4;
    bus.req_valid[3] = 1'b1;
    wait_ready("ro_accept", '1);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    @(posedge clk); #1;
    chk("ro_holding", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zeroed("rst_out");
    rst_n = 1'b1;
    bus.req_valid = '1;
    @(negedge clk);
    chk("rst_out_prio", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic; requesters hold valid/data until accepted, may withdraw
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      seen = bus.req_ready;
      @(posedge clk); #1;
      rst_n = ($urandom % 150 != 0);
      bus.out_ready = ($urandom % 4 != 0);
      for (int i = 0; i < int'(NR); i++) begin
        if (bus.req_valid[i] && seen[i]) begin
          bus.req_valid[i] = 1'($urandom % 2);
          bus.req_data[13*i +: 13] = rnd_d();
        end else if (bus.req_valid[i]) begin
          if ($urandom % 16 == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom % 2 == 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[13*i +: 13] = rnd_d();
        end
      end
    end
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
